led_bargraph_peak: RTL
======================

LED_BARGRAPH_PEAK -- requirements
Module: led_bargraph_peak

Interface
REQ-001 Parameter DATA_W, default 8, width of the signed sample.
REQ-002 Parameter LED_W, default 8, number of LEDs; power of two, 2..2^DATA_W.
REQ-003 Parameter NUM_CH, default 3, number of sample channels (x/y/z); 1..4.
REQ-004 Parameter HOLD_CYCLES, default 16, clocks a new peak is held before decay starts.
REQ-005 Parameter DECAY_CYCLES, default 4, clocks per one-level peak decrement.
REQ-006 Parameter SCAN_CYCLES, default 64, clocks per channel in auto-scan mode.
REQ-007 sys_clock  in  1  single clock; all state updates on its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 o_sync  in  1  sample strobe; data and ch_id are valid when high.
REQ-010 ch_id  in  2  channel tag of the current sample.
REQ-011 data  in  DATA_W  signed two's-complement sample.
REQ-012 sel_ch  in  2  channel to display in modes 0-2.
REQ-013 mode  in  2  0 BAR, 1 BAR+PEAK, 2 DOT, 3 AUTO-SCAN.
REQ-014 LEDR  out  LED_W  registered LED drive, 1 = lit.

Function
REQ-015 The block SHALL hold one sample register per channel, loaded with data when o_sync=1 and ch_id<NUM_CH.
REQ-016 Samples with ch_id>=NUM_CH SHALL be ignored, with no state change.
REQ-017 Offset value u SHALL be data with its MSB inverted (-2^(DATA_W-1)..2^(DATA_W-1)-1 maps to 0..2^DATA_W-1).
REQ-018 Level SHALL be (u*LED_W)>>DATA_W, range 0..LED_W-1, with no saturation logic needed.
REQ-019 Bar pattern SHALL light bits 0..level-1 (level 0 = all dark).
REQ-020 Each channel SHALL hold a peak level register and a hold/decay counter.
REQ-021 On an accepted sample with level>=peak, peak SHALL load level and the counter SHALL reload HOLD_CYCLES.
REQ-022 Otherwise, after HOLD_CYCLES elapse, peak SHALL decrement by 1 every DECAY_CYCLES, never below the channel's current level.
REQ-023 An accepted sample with level>=peak in the same cycle as a decay tick SHALL win: load, no decrement.
REQ-024 Mode 0 SHALL drive the bar of sel_ch.
REQ-025 Mode 1 SHALL drive the bar of sel_ch OR'd with a single bit at index peak.
REQ-026 Mode 2 SHALL drive exactly one lit bit, at index level of sel_ch.
REQ-027 Mode 3 SHALL drive the mode-1 pattern of a scan channel that advances 0,1,..,NUM_CH-1,0 every SCAN_CYCLES clocks, ignoring sel_ch.
REQ-028 In modes 0-2, sel_ch>=NUM_CH SHALL drive LEDR=0.
REQ-029 Latency: o_sync at edge n updates the sample/peak at edge n; LEDR reflects it at edge n+1.
REQ-030 mode and sel_ch changes SHALL take effect on the next LEDR update, without disturbing peak or scan state.
REQ-031 The scan counter SHALL run continuously, but its channel index SHALL advance only while mode=3.

Reset
REQ-032 While reset=1 at an edge, LEDR SHALL load all ones (lamp test).
REQ-033 Reset SHALL set every sample to 0 (u = 2^(DATA_W-1), level LED_W/2), every peak to LED_W/2, every counter to 0, and the scan channel to 0.
REQ-034 Reset SHALL override o_sync in the same cycle; a mid-hold or mid-decay reset SHALL discard the hold.
REQ-035 On the first edge after reset deasserts, LEDR SHALL show the post-reset display (mode 0 = 8'h0F at defaults).

Verification (defaults)
REQ-036 Reset 3 clocks, mode 0, sel_ch 0 -> LEDR 8'hFF during reset, then 8'h0F.
REQ-037 Mode 0: o_sync ch0 data 8'h7F -> LEDR 8'h7F one edge later; data 8'h80 -> LEDR 8'h00.
REQ-038 Mode 1: ch0 data 8'h60 (level 7), then data 8'h00 (level 4) -> LEDR 8'h8F held 16 clocks, then 8'h4F, 8'h2F, 8'h1F at 4-clock steps, stopping at 8'h1F.
REQ-039 Mode 2: ch1 data 8'hE0 (level 3), sel_ch 1 -> LEDR 8'h08; o_sync with ch_id 3 -> LEDR unchanged.
REQ-040 Mode 3, ch0..2 at levels 7/4/1 -> LEDR cycles through the three channel patterns, each for 64 clocks, then wraps to ch0.
REQ-041 Mode 1: a new-peak sample in the same cycle as a decay tick -> peak equals the new level and hold restarts; reset asserted mid-decay -> LEDR 8'hFF, then 8'h1F.

Source files
------------

// File: rtl/led_bargraph_peak.sv
// Multi-channel LED bargraph with per-channel peak hold/decay.
// Modes: bar, bar+peak, dot, and auto-scan across channels.
module led_bargraph_peak #(
    parameter int DATA_W       = 8,
    parameter int LED_W        = 8,
    parameter int NUM_CH       = 3,
    parameter int HOLD_CYCLES  = 16,
    parameter int DECAY_CYCLES = 4,
    parameter int SCAN_CYCLES  = 64
) (
    input  logic              sys_clock,
    input  logic              reset,
    input  logic              o_sync,
    input  logic [1:0]        ch_id,
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        sel_ch,
    input  logic [1:0]        mode,
    output logic [LED_W-1:0]  LEDR
);

    localparam int LW   = $clog2(LED_W);
    localparam int CMAX = (HOLD_CYCLES > DECAY_CYCLES) ? HOLD_CYCLES
                                                       : DECAY_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int SW   = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

    localparam logic [LW-1:0] MID       = LW'(LED_W / 2);
    localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] DECAY_LD  = CW'(DECAY_CYCLES);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
    localparam logic [1:0]    LAST_CH   = 2'(NUM_CH - 1);

    // Offset-binary conversion then keep the top LW bits.
    function automatic logic [LW-1:0] to_level(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] u;
        u = {~d[DATA_W-1], d[DATA_W-2:0]};
        return LW'(u >> (DATA_W - LW));
    endfunction

    function automatic logic [LED_W-1:0] bar(input logic [LW-1:0] l);
        return (LED_W'(1) << l) - LED_W'(1);
    endfunction

    logic [DATA_W-1:0] samp  [NUM_CH];
    logic [LW-1:0]     peak  [NUM_CH];
    logic [CW-1:0]     cnt   [NUM_CH];
    logic [LW-1:0]     level [NUM_CH];
    logic [LW-1:0]     cur   [NUM_CH];
    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] tick;
    logic [LW-1:0]     new_lvl;

    logic [SW-1:0]     scan_cnt;
    logic [1:0]        scan_ch;
    logic              scan_wrap;
    logic [LED_W-1:0]  disp;

    always_comb begin
        new_lvl = to_level(data);
        for (int c = 0; c < NUM_CH; c++) begin
            level[c] = to_level(samp[c]);
            hit[c]   = o_sync && (ch_id == 2'(c));
            load[c]  = hit[c] && (new_lvl >= peak[c]);
            cur[c]   = hit[c] ? new_lvl : level[c];
            tick[c]  = (cnt[c] <= CW'(1));
        end
    end

    // A qualifying sample beats a decay tick; decay never drops below level.
    always_ff @(posedge sys_clock) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (reset) begin
                samp[c] <= '0;
                peak[c] <= MID;
                cnt[c]  <= '0;
            end else begin
                if (hit[c]) samp[c] <= data;
                if (load[c]) begin
                    peak[c] <= new_lvl;
                    cnt[c]  <= HOLD_LD;
                end else if (tick[c]) begin
                    cnt[c] <= DECAY_LD;
                    if (peak[c] > cur[c]) peak[c] <= peak[c] - LW'(1);
                end else begin
                    cnt[c] <= cnt[c] - CW'(1);
                end
            end
        end
    end

    assign scan_wrap = (scan_cnt == SCAN_LAST);

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            scan_cnt <= '0;
            scan_ch  <= 2'd0;
        end else begin
            scan_cnt <= scan_wrap ? '0 : scan_cnt + SW'(1);
            if (scan_wrap && mode == 2'd3)
                scan_ch <= (scan_ch == LAST_CH) ? 2'd0 : scan_ch + 2'd1;
        end
    end

    always_comb begin
        logic          s_ok;
        logic [LW-1:0] s_lvl;
        logic [LW-1:0] s_pk;
        logic [LW-1:0] a_lvl;
        logic [LW-1:0] a_pk;
        s_ok  = 1'b0;
        s_lvl = '0;
        s_pk  = '0;
        a_lvl = '0;
        a_pk  = '0;
        disp  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (sel_ch == 2'(c)) begin
                s_ok  = 1'b1;
                s_lvl = level[c];
                s_pk  = peak[c];
            end
            if (scan_ch == 2'(c)) begin
                a_lvl = level[c];
                a_pk  = peak[c];
            end
        end
        unique case (mode)
            2'd0: disp = s_ok ? bar(s_lvl) : '0;
            2'd1: disp = s_ok ? (bar(s_lvl) | (LED_W'(1) << s_pk)) : '0;
            2'd2: disp = s_ok ? (LED_W'(1) << s_lvl) : '0;
            2'd3: disp = bar(a_lvl) | (LED_W'(1) << a_pk);
        endcase
    end

    always_ff @(posedge sys_clock) begin
        if (reset) LEDR <= '1;
        else       LEDR <= disp;
    end

endmodule
